// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi front-end and tamagotchi_fsm.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package tamagotchi_pkg;

  localparam int unsigned CLK_HZ_DEFAULT      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;
  localparam int unsigned HOLD_SECS_DEFAULT   = 5;

  // Pet status levels shared with tamagotchi_fsm
  localparam logic [2:0] LEVEL_MIN = 3'd0;
  localparam logic [2:0] LEVEL_MAX = 3'd4;

  // 7-segment patterns, active-low, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  // Hold-timer state encoding
  typedef logic hold_state_t;
  localparam hold_state_t HOLD_IDLE   = 1'b0;
  localparam hold_state_t HOLD_ACTIVE = 1'b1;

  // Debounce length in clock cycles for a given clock and stable time
  function automatic int unsigned db_cycles(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Decimal digit to 7-segment pattern (blank for anything above 9)
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b100_0000;
      4'd1:    return 7'b111_1001;
      4'd2:    return 7'b010_0100;
      4'd3:    return 7'b011_0000;
      4'd4:    return 7'b001_1001;
      4'd5:    return 7'b001_0010;
      4'd6:    return 7'b000_0010;
      4'd7:    return 7'b111_1000;
      4'd8:    return 7'b000_0000;
      4'd9:    return 7'b001_0000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronise one raw pad, debounce it and emit a 1-cycle press pulse.
// Latency: pad edge to press_pulse = 2 sync + DB_CYCLES + 1 cycles; level is one cycle earlier.
// Backpressure: none; the pad cannot be stalled, glitches shorter than DB_CYCLES are dropped.
module button_debouncer #(
  parameter int unsigned DB_CYCLES  = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned    CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  // Pad value when the button is released
  localparam logic           RAW_IDLE = ACTIVE_LOW;

  logic             sync_q1;
  logic             sync_q2;
  logic             pressed;
  logic             stable_q;
  logic             stable_d_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser, reset to the released pad level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RAW_IDLE;
      sync_q2 <= RAW_IDLE;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // 1 = pressed regardless of pad polarity
  assign pressed = sync_q2 ^ RAW_IDLE;

  // Flip the stable state only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (pressed == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      stable_q <= pressed;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered rising-edge detector on the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_q  <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      stable_d_q  <= stable_q;
      press_pulse <= stable_q & ~stable_d_q;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/tamagotchi_button_conditioner.sv
// Clean the six board buttons: action presses as pulses, reset/test as timed holds.
// Latency: action pulse 2+DB_CYCLES+1 cycles after the pad edge; hold seconds count from debounced press.
// Backpressure: none; outputs are free-running pulses/levels, reset hold overrides the test timer.
module tamagotchi_button_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int unsigned CLK_HZ         = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_MS    = DEBOUNCE_MS_DEFAULT,
  parameter int unsigned HOLD_SECS      = HOLD_SECS_DEFAULT,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_salud,
  input  logic       raw_energia,
  input  logic       raw_hambre,
  input  logic       raw_diversion,
  input  logic       raw_reset,
  input  logic       raw_test,
  output logic       btn_salud,
  output logic       btn_energia,
  output logic       btn_hambre,
  output logic       btn_diversion,
  output logic       btn_reset,
  output logic       btn_test,
  output logic [2:0] count_reset,
  output logic [2:0] count_test
);

  localparam int unsigned DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned PRESC_W   = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [2:0] SECS_SAT = 3'(HOLD_SECS);
  localparam logic [2:0] SECS_PRE = 3'(HOLD_SECS - 1);

  // Button slots in the debouncer array
  localparam int unsigned NUM_BTN   = 6;
  localparam int unsigned IDX_RESET = 4;
  localparam int unsigned IDX_TEST  = 5;

  // Hold-timer slots
  localparam int unsigned TMR_RESET = 0;
  localparam int unsigned TMR_TEST  = 1;

  if (HOLD_SECS < 1 || HOLD_SECS > 7) begin : g_bad_hold_secs
    $fatal(1, "HOLD_SECS must be in 1..7");
  end

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] lvl_vec;
  logic [NUM_BTN-1:0] press_vec;

  assign raw_vec = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_debouncer #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (raw_vec[i]),
      .level       (lvl_vec[i]),
      .press_pulse (press_vec[i])
    );
  end

  assign btn_salud     = press_vec[0];
  assign btn_energia   = press_vec[1];
  assign btn_hambre    = press_vec[2];
  assign btn_diversion = press_vec[3];

  // Action levels and hold-button pulses are not needed downstream
  logic unused_ok;
  assign unused_ok = ^{lvl_vec[3:0], press_vec[IDX_TEST], press_vec[IDX_RESET]};

  hold_state_t [1:0]              state_q, state_nxt;
  logic        [1:0][PRESC_W-1:0] presc_q, presc_nxt;
  logic        [1:0][2:0]         secs_q,  secs_nxt;
  logic        [1:0]              fire_q,  fire_nxt;
  logic        [1:0]              held;
  logic        [1:0]              force_idle;

  assign held[TMR_RESET]       = lvl_vec[IDX_RESET];
  assign held[TMR_TEST]        = lvl_vec[IDX_TEST];
  // Reset hold wins: the test timer is parked while reset is pressed
  assign force_idle[TMR_RESET] = 1'b0;
  assign force_idle[TMR_TEST]  = lvl_vec[IDX_RESET];

  // Hold-timer next state: prescaler, saturating seconds and the one-shot fire pulse
  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    secs_nxt  = secs_q;
    fire_nxt  = '0;
    for (int t = 0; t < 2; t++) begin
      if (force_idle[t] || !held[t]) begin
        state_nxt[t] = HOLD_IDLE;
        presc_nxt[t] = '0;
        secs_nxt[t]  = '0;
      end else if (state_q[t] == HOLD_IDLE) begin
        state_nxt[t] = HOLD_ACTIVE;
      end else if (presc_q[t] == PRESC_LAST) begin
        presc_nxt[t] = '0;
        if (secs_q[t] != SECS_SAT) begin
          secs_nxt[t] = secs_q[t] + 3'd1;
          fire_nxt[t] = (secs_q[t] == SECS_PRE);
        end
      end else begin
        presc_nxt[t] = presc_q[t] + 1'b1;
      end
    end
  end

  // Hold-timer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {2{HOLD_IDLE}};
      presc_q <= '0;
      secs_q  <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_nxt;
      presc_q <= presc_nxt;
      secs_q  <= secs_nxt;
      fire_q  <= fire_nxt;
    end
  end

  assign btn_reset   = fire_q[TMR_RESET];
  assign btn_test    = fire_q[TMR_TEST];
  assign count_reset = secs_q[TMR_RESET];
  assign count_test  = secs_q[TMR_TEST];

endmodule

// File: tb/tb_tamagotchi_button_conditioner.sv
module tb_tamagotchi_button_conditioner;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned DEBOUNCE_MS = 4;
  localparam int unsigned HOLD_SECS   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_salud = 1'b1, raw_energia = 1'b1, raw_hambre = 1'b1;
  logic       raw_diversion = 1'b1, raw_reset = 1'b1, raw_test = 1'b1;
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
  logic [2:0] count_reset, count_test;
  logic [11:0] all_out;

  int n_vec = 0;
  int n_err = 0;

  tamagotchi_button_conditioner #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_MS    (DEBOUNCE_MS),
    .HOLD_SECS      (HOLD_SECS),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_salud     (raw_salud),
    .raw_energia   (raw_energia),
    .raw_hambre    (raw_hambre),
    .raw_diversion (raw_diversion),
    .raw_reset     (raw_reset),
    .raw_test      (raw_test),
    .btn_salud     (btn_salud),
    .btn_energia   (btn_energia),
    .btn_hambre    (btn_hambre),
    .btn_diversion (btn_diversion),
    .btn_reset     (btn_reset),
    .btn_test      (btn_test),
    .count_reset   (count_reset),
    .count_test    (count_test)
  );

  assign all_out = {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
                    count_reset, count_test};

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int activity = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (all_out !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 000", all_out);
    end
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (all_out !== 12'h000) activity++;
    end
    n_vec++;
    if (activity !== 0) begin
      n_err++;
      $display("FAIL idle_after_reset: %0d active cycles, want 0", activity);
    end
  endtask

  task automatic test_glitch_reject();
    int pulses = 0;
    raw_energia = 1'b0;
    repeat (3) begin tick(); if (btn_energia) pulses++; end
    raw_energia = 1'b1;
    repeat (20) begin tick(); if (btn_energia) pulses++; end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL glitch_reject: %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_press_latency();
    int pulses = 0;
    int first = 0;
    raw_energia = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (btn_energia) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL energia_pulse_count: got %0d want 1", pulses);
    end
    n_vec++;
    if (first !== 7) begin
      n_err++;
      $display("FAIL energia_latency: got %0d want 7", first);
    end
    pulses = 0;
    raw_energia = 1'b1;
    repeat (20) begin tick(); if (btn_energia) pulses++; end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL energia_release: %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int first = 0;
    for (int i = 0; i < 20; i++) begin
      raw_salud = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      if (btn_salud) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL salud_bounce: %0d pulses while bouncing, want 0", pulses);
    end
    raw_salud = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (btn_salud) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    n_vec++;
    if (pulses !== 1 || first !== 7) begin
      n_err++;
      $display("FAIL salud_settle: %0d pulses at %0d, want 1 at 7", pulses, first);
    end
    pulses = 0;
    raw_salud = 1'b1;
    repeat (30) begin tick(); if (btn_salud) pulses++; end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL salud_release: %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int at_h = 0;
    int at_d = 0;
    int others = 0;
    raw_hambre    = 1'b0;
    raw_diversion = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (btn_hambre && at_h == 0) at_h = i;
      if (btn_diversion && at_d == 0) at_d = i;
      if (btn_salud || btn_energia) others++;
    end
    n_vec++;
    if (at_h !== 7 || at_d !== 7) begin
      n_err++;
      $display("FAIL simultaneous: hambre at %0d diversion at %0d, want 7 and 7", at_h, at_d);
    end
    n_vec++;
    if (others !== 0) begin
      n_err++;
      $display("FAIL crosstalk: %0d stray pulses, want 0", others);
    end
    raw_hambre    = 1'b1;
    raw_diversion = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_reset_hold();
    int prev = 0;
    int steps = 0;
    int pulses = 0;
    int pulse_at = 0;
    int rel_pulses = 0;
    raw_reset = 1'b0;
    for (int i = 1; i <= 6000; i++) begin
      tick();
      if (count_reset !== 3'(prev)) begin
        steps++;
        n_vec++;
        if (count_reset !== 3'(prev + 1) || i != 7 + 1000 * (prev + 1)) begin
          n_err++;
          $display("FAIL reset_step: count %0d at cycle %0d, want %0d at %0d",
                   count_reset, i, prev + 1, 7 + 1000 * (prev + 1));
        end
        prev = int'(count_reset);
      end
      if (btn_reset) begin
        pulses++;
        pulse_at = i;
      end
    end
    n_vec++;
    if (steps !== 5 || count_reset !== 3'd5) begin
      n_err++;
      $display("FAIL reset_saturate: %0d steps ending at %0d, want 5 steps ending at 5", steps, count_reset);
    end
    n_vec++;
    if (pulses !== 1 || pulse_at !== 5007) begin
      n_err++;
      $display("FAIL btn_reset_fire: %0d pulses, last at %0d, want 1 at 5007", pulses, pulse_at);
    end
    raw_reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (btn_reset) rel_pulses++;
      if (i == 6) begin
        n_vec++;
        if (count_reset !== 3'd5) begin
          n_err++;
          $display("FAIL reset_release_hold: count %0d at cycle 6, want 5", count_reset);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (count_reset !== 3'd0) begin
          n_err++;
          $display("FAIL reset_release_clear: count %0d at cycle 7, want 0", count_reset);
        end
      end
    end
    n_vec++;
    if (rel_pulses !== 0) begin
      n_err++;
      $display("FAIL reset_release_pulse: %0d pulses, want 0", rel_pulses);
    end
  endtask

  task automatic test_test_short();
    int peak = 0;
    int pulses = 0;
    raw_test = 1'b0;
    repeat (3500) begin
      tick();
      if (int'(count_test) > peak) peak = int'(count_test);
      if (btn_test) pulses++;
    end
    raw_test = 1'b1;
    repeat (10) begin
      tick();
      if (btn_test) pulses++;
    end
    n_vec++;
    if (peak !== 3) begin
      n_err++;
      $display("FAIL test_peak: got %0d want 3", peak);
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL test_short_pulse: %0d pulses, want 0", pulses);
    end
    n_vec++;
    if (count_test !== 3'd0) begin
      n_err++;
      $display("FAIL test_short_clear: count %0d, want 0", count_test);
    end
  endtask

  task automatic test_reset_priority();
    int reached = 0;
    int r_pulses = 0;
    int r_at = 0;
    int t_pulses = 0;
    int t_nonzero = 0;
    raw_test = 1'b0;
    for (int i = 1; i <= 2100 && reached == 0; i++) begin
      tick();
      if (count_test === 3'd2) reached = i;
    end
    n_vec++;
    if (reached !== 2007) begin
      n_err++;
      $display("FAIL test_reach_2: at cycle %0d, want 2007", reached);
    end
    raw_reset = 1'b0;
    for (int i = 1; i <= 5100; i++) begin
      tick();
      if (i == 6) begin
        n_vec++;
        if (count_test !== 3'd2) begin
          n_err++;
          $display("FAIL priority_before: count_test %0d at cycle 6, want 2", count_test);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (count_test !== 3'd0) begin
          n_err++;
          $display("FAIL priority_clear: count_test %0d at cycle 7, want 0", count_test);
        end
      end
      if (i >= 7 && count_test !== 3'd0) t_nonzero++;
      if (btn_test) t_pulses++;
      if (btn_reset) begin
        r_pulses++;
        r_at = i;
      end
    end
    n_vec++;
    if (r_pulses !== 1 || r_at !== 5007) begin
      n_err++;
      $display("FAIL priority_reset_fire: %0d pulses, last at %0d, want 1 at 5007", r_pulses, r_at);
    end
    n_vec++;
    if (t_pulses !== 0 || t_nonzero !== 0) begin
      n_err++;
      $display("FAIL priority_test_parked: %0d pulses, %0d nonzero cycles, want 0 and 0", t_pulses, t_nonzero);
    end
    raw_reset = 1'b1;
    raw_test  = 1'b1;
    repeat (20) tick();
    n_vec++;
    if ({count_reset, count_test} !== 6'd0) begin
      n_err++;
      $display("FAIL priority_release: counts %0d/%0d, want 0/0", count_reset, count_test);
    end
  endtask

  task automatic test_async_reset();
    int reached = 0;
    int first1 = 0;
    int pulses = 0;
    int pulse_at = 0;
    raw_reset = 1'b0;
    for (int i = 1; i <= 3100 && reached == 0; i++) begin
      tick();
      if (count_reset === 3'd3) reached = i;
    end
    n_vec++;
    if (reached !== 3007) begin
      n_err++;
      $display("FAIL async_reach_3: at cycle %0d, want 3007", reached);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_out !== 12'h000) begin
      n_err++;
      $display("FAIL async_clear: got %h want 000", all_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 5100; i++) begin
      tick();
      if (count_reset === 3'd1 && first1 == 0) first1 = i;
      if (btn_reset) begin
        pulses++;
        pulse_at = i;
      end
    end
    n_vec++;
    if (first1 !== 1007) begin
      n_err++;
      $display("FAIL async_restart: count 1 at cycle %0d, want 1007", first1);
    end
    n_vec++;
    if (pulses !== 1 || pulse_at !== 5007) begin
      n_err++;
      $display("FAIL async_refire: %0d pulses, last at %0d, want 1 at 5007", pulses, pulse_at);
    end
    raw_reset = 1'b1;
    repeat (20) tick();
    n_vec++;
    if (all_out !== 12'h000) begin
      n_err++;
      $display("FAIL async_final_idle: got %h want 000", all_out);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_reject();
    test_press_latency();
    test_bounce();
    test_simultaneous();
    test_reset_hold();
    test_test_short();
    test_reset_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
